rom_ram_datapath: RTL
=====================

# rom_ram_datapath

Datapath stage driven directly by the ROM-to-RAM control unit: it consumes `read_rom`/`rom_addr` and `write_ram`/`ram_addr`, and moves 8-bit words from a fixed 8-entry ROM through a holding register into an 8-entry RAM. It also keeps transfer status (write count, running checksum, done, sequencing error) and provides a registered readback port so the copied contents can be checked after a transfer.

## Interface
Parameters:
- `DATA_W`, 8, data word width.
- `ADDR_W`, 3, address width; depth = 2**ADDR_W = 8.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `read_rom`  in  1  load ROM word at `rom_addr` into the holding register.
- `rom_addr`  in  ADDR_W  ROM read address.
- `write_ram`  in  1  write the holding register into RAM at `ram_addr`.
- `ram_addr`  in  ADDR_W  RAM write address.
- `clear`  in  1  synchronous clear of status state; RAM contents are kept.
- `rd_addr`  in  ADDR_W  readback address.
- `rd_data`  out  DATA_W  registered RAM readback.
- `hold_data`  out  DATA_W  current holding-register value.
- `wr_count`  out  ADDR_W+1  number of accepted RAM writes, saturating at 8.
- `checksum`  out  DATA_W  sum of all written words, modulo 256.
- `done`  out  1  sticky; set when `wr_count` reaches 8.
- `err`  out  1  sticky; set on a write with no fresh data.

## Operation
- ROM contents are fixed: `rom[i] = 8'h11 * (i+1)`, giving 0x11, 0x22, … 0x88 for i = 0 … 7.
- Internal `hold_valid` flag:
  - Set by `read_rom`.
  - Cleared by a `write_ram` that is not accompanied by `read_rom`.
- `read_rom`: `hold_data <= rom[rom_addr]`; `hold_valid <= 1`.
- `write_ram`:
  - `ram[ram_addr] <= hold_data`, using the value before this edge's update.
  - `checksum <= checksum + hold_data`, truncated to 8 bits.
  - `wr_count` increments, saturating at 8.
  - If `hold_valid == 0`, the write is still performed and counted, and `err <= 1`.
- `read_rom` and `write_ram` in the same cycle: the write uses the old `hold_data`, the read loads the new value, and `hold_valid` ends at 1. This gives back-to-back streaming with no `err`.
- `done <= 1` on the edge where `wr_count` becomes 8. It stays set until `clear` or `rst`.
- Further writes after saturation: RAM and `checksum` still update; `wr_count` stays at 8.
- `clear` (priority over status updates in the same cycle):
  - `wr_count`, `checksum`, `done`, `err` and `hold_valid` go to 0.
  - A coincident `write_ram` still writes RAM.
  - A coincident `read_rom` still loads `hold_data`, but `hold_valid` ends at 0.
- Readback: `rd_data <= ram[rd_addr]` every cycle, read-before-write.
- Address wrap is natural 3-bit; there are no out-of-range addresses.

## Timing
- Reset values (asynchronous, immediate): `hold_data`, `rd_data`, `checksum` = 0; `wr_count` = 0; `done`, `err`, `hold_valid` = 0; all 8 RAM words = 0.
- `read_rom` sampled at edge k: `hold_data` is valid after edge k.
- `write_ram` at edge k+1 commits that word. The minimum ROM-to-RAM latency is 1 cycle.
- `rd_data`: 1-cycle latency from `rd_addr`. A same-address write at the same edge returns the old word; the new word appears one edge later.
- `checksum`, `wr_count` and `done` update at the same edge as the RAM write. `done` is visible in the cycle after the eighth write edge.
- `rst` asserted mid-transfer: all state and the RAM return to reset values immediately, and in-flight data is discarded. After release, the first edge behaves as from reset.

## Test plan
- Reset then idle: after `rst` pulse, all outputs are 0; `rd_data` reads 0 for addresses 0–7.
- Sequential copy: for i = 0..7, pulse `read_rom` (addr i) then `write_ram` (addr i).
  - Expected: `wr_count` = 8, `done` = 1, `err` = 0.
  - Expected: `checksum` = 0x11+…+0x88 mod 256 = 0x64.
  - Readback of address i returns 0x11*(i+1).
- Streaming overlap: `read_rom` addr 0; then 7 cycles of `read_rom` (addr i+1) together with `write_ram` (addr i); then `write_ram` addr 7. Expected: same RAM contents and checksum as the sequential copy, and `err` = 0.
- Underrun: `write_ram` to addr 3 straight after reset. Expected: `err` = 1, `ram[3]` = 0x00, `wr_count` = 1. Then a normal read/write of addr 5 leaves `err` at 1.
- Same-address readback: `rd_addr` = 2 held while `write_ram` writes 0x33 to addr 2. Expected: `rd_data` = old value on the first edge, 0x33 on the next.
- Clear and reset mid-operation:
  - `clear` after 4 writes: counters, `checksum`, `done` and `err` go to 0; RAM keeps its words.
  - `rst` asserted between a read and a write: RAM is zeroed, and the next write with no new read flags `err`.

Source files
------------

// File: rtl/rom_ram_datapath.sv
// ROM-to-RAM datapath: fixed 8-word ROM, holding register, 8-word RAM,
// transfer status (count, checksum, done, err) and registered readback.
module rom_ram_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_rom,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic              write_ram,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hold_data,
  output logic [ADDR_W:0]   wr_count,
  output logic [DATA_W-1:0] checksum,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] INC = {{ADDR_W{1'b0}}, 1'b1};

  function automatic logic [DATA_W-1:0] rom_word(
    input logic [ADDR_W-1:0] a
  );
    return DATA_W'(17 * (int'(a) + 1));
  endfunction

  logic [DATA_W-1:0] ram_q [DEPTH];
  logic [DATA_W-1:0] ram_d [DEPTH];
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Data movement: ROM load, RAM write with old hold value, readback
  always_comb begin
    ram_d  = ram_q;
    hold_d = hold_q;
    rd_d   = ram_q[rd_addr];
    if (write_ram) ram_d[ram_addr] = hold_q;
    if (read_rom)  hold_d = rom_word(rom_addr);
  end

  // Status: clear wins; count saturates; done/err are sticky
  always_comb begin
    hold_valid_d = hold_valid_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    done_d       = done_q;
    err_d        = err_q;
    if (read_rom)       hold_valid_d = 1'b1;
    else if (write_ram) hold_valid_d = 1'b0;
    if (write_ram) begin
      sum_d = sum_q + hold_q;
      if (cnt_q != FULL) cnt_d = cnt_q + INC;
      if (!hold_valid_q) err_d = 1'b1;
    end
    if (cnt_d == FULL) done_d = 1'b1;
    if (clear) begin
      hold_valid_d = 1'b0;
      cnt_d        = '0;
      sum_d        = '0;
      done_d       = 1'b0;
      err_d        = 1'b0;
    end
  end

  // State registers, all cleared by async reset including the RAM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_q        <= '{default: '0};
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      rd_q         <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ram_q        <= ram_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rd_data   = rd_q;
  assign hold_data = hold_q;
  assign wr_count  = cnt_q;
  assign checksum  = sum_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
